norm_round_unit: RTL and testbench

//  Parametrised, multi-cycle normalise-and-round stage for the FP multiplier datapath.
//  - Input: raw double-width significand product, sign, and pre-biased exponent.
//  - Output: IEEE-style packed mantissa/exponent/sign plus exception flags.
//  - Does 1-bit right normalisation, iterative left normalisation, and round-to-nearest-even.
//  - Detects overflow and underflow; ready/valid handshake on both sides.

---
 rtl/norm_round_unit_if.sv | 33 +++
 rtl/norm_round_unit.sv | 172 +++++++++++++++++
 tb/tb_norm_round_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/norm_round_unit_if.sv
// Handshake bundle for the normalise-and-round stage: upstream operand channel plus downstream result channel.
// The master drives operands and result acceptance; the slave is the rounding stage.
interface norm_round_unit_if #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int PROD_W = 2*MANT_W+2
);
  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [EXP_W+1:0]    in_exp;
  logic [PROD_W-1:0]   in_frac;
  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic [EXP_W-1:0]    out_exp;
  logic [MANT_W-1:0]   out_frac;
  logic                out_overflow;
  logic                out_underflow;
  logic                out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_frac, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_frac,
           out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_frac,
           out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/norm_round_unit.sv
// Multi-cycle normalise and round-to-nearest-even stage for the FP multiplier datapath.
// One operand in flight at a time; left normalisation walks one bit per cycle.
module norm_round_unit #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int PROD_W = 2*MANT_W+2
) (
  input  logic              clk,
  input  logic              rst,
  norm_round_unit_if.slave  bus
);

  localparam int EW        = EXP_W + 2;
  localparam int GUARD_IDX = PROD_W - 3 - MANT_W;

  localparam logic signed [EW-1:0] EXP_ZERO    = '0;
  localparam logic signed [EW-1:0] EXP_ONE     = EW'(1);
  localparam logic signed [EW-1:0] EXP_POS_MAX = {1'b0, {(EW-1){1'b1}}};
  localparam logic signed [EW-1:0] EXP_ALL1    = EW'((1 << EXP_W) - 1);
  localparam logic [PROD_W-1:0]    LOW_MASK    = (PROD_W'(1) << GUARD_IDX) - PROD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_sign;
  logic signed [EW-1:0]   r_exp;
  logic [PROD_W-1:0]      r_frac;
  logic                   r_sticky;
  logic                   r_zero;

  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_out_sign;
  logic [EXP_W-1:0]       r_out_exp;
  logic [MANT_W-1:0]      r_out_frac;
  logic                   r_out_overflow;
  logic                   r_out_underflow;
  logic                   r_out_inexact;

  logic [MANT_W-1:0]      w_mant;
  logic                   w_guard;
  logic                   w_sticky;
  logic                   w_round_up;
  logic [MANT_W:0]        w_mant_rnd;
  logic signed [EW-1:0]   w_exp_rnd;

  // Exponent increments saturate so the signed internal exponent can never wrap.
  function automatic logic signed [EW-1:0] sat_inc(input logic signed [EW-1:0] e);
    if (e == EXP_POS_MAX)
      return e;
    return e + EXP_ONE;
  endfunction

  always_comb begin
    w_mant     = r_frac[PROD_W-3 -: MANT_W];
    w_guard    = r_frac[GUARD_IDX];
    w_sticky   = (|(r_frac & LOW_MASK)) | r_sticky;
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + (MANT_W+1)'(w_round_up);
    w_exp_rnd  = w_mant_rnd[MANT_W] ? sat_inc(r_exp) : r_exp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_sign          <= 1'b0;
      r_exp           <= '0;
      r_frac          <= '0;
      r_sticky        <= 1'b0;
      r_zero          <= 1'b0;
      r_in_ready      <= 1'b1;
      r_out_valid     <= 1'b0;
      r_out_sign      <= 1'b0;
      r_out_exp       <= '0;
      r_out_frac      <= '0;
      r_out_overflow  <= 1'b0;
      r_out_underflow <= 1'b0;
      r_out_inexact   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_sign     <= bus.in_sign;
            r_exp      <= $signed(bus.in_exp);
            r_frac     <= bus.in_frac;
            r_sticky   <= 1'b0;
            r_zero     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_NORM;
          end
        end

        S_NORM: begin
          if (r_frac == '0) begin
            r_zero  <= 1'b1;
            r_state <= S_ROUND;
          end else if (r_frac[PROD_W-1]) begin
            r_frac   <= r_frac >> 1;
            r_sticky <= r_sticky | r_frac[0];
            r_exp    <= sat_inc(r_exp);
            r_state  <= S_ROUND;
          end else if (r_frac[PROD_W-2] || (r_exp <= EXP_ZERO)) begin
            r_state <= S_ROUND;
          end else begin
            // Decrement only happens with exp > 0, so no underflow wrap here.
            r_frac <= r_frac << 1;
            r_exp  <= r_exp - EXP_ONE;
          end
        end

        S_ROUND: begin
          r_out_sign  <= r_sign;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
          if (r_zero) begin
            r_out_exp       <= '0;
            r_out_frac      <= '0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
            r_out_inexact   <= 1'b0;
          end else if (r_exp <= EXP_ZERO) begin
            r_out_exp       <= '0;
            r_out_frac      <= '0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b1;
            r_out_inexact   <= 1'b1;
          end else if (w_exp_rnd >= EXP_ALL1) begin
            r_out_exp       <= '1;
            r_out_frac      <= '0;
            r_out_overflow  <= 1'b1;
            r_out_underflow <= 1'b0;
            r_out_inexact   <= 1'b1;
          end else begin
            // A mantissa carry-out leaves the low MANT_W bits at zero, which is the wanted result.
            r_out_exp       <= w_exp_rnd[EXP_W-1:0];
            r_out_frac      <= w_mant_rnd[MANT_W-1:0];
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
            r_out_inexact   <= w_guard | w_sticky;
          end
        end

        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_sign      = r_out_sign;
  assign bus.out_exp       = r_out_exp;
  assign bus.out_frac      = r_out_frac;
  assign bus.out_overflow  = r_out_overflow;
  assign bus.out_underflow = r_out_underflow;
  assign bus.out_inexact   = r_out_inexact;

endmodule

// File: tb/tb_norm_round_unit.sv
// Scoreboard bench for norm_round_unit: expected results queued at drive time, compared on out_valid.
// Covers rounding ties, carry-out, left normalisation latency, flags, back-pressure and mid-op reset.
module tb_norm_round_unit;
  localparam int MANT_W = 23;
  localparam int EXP_W  = 8;
  localparam int PROD_W = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  norm_round_unit_if #(.MANT_W(MANT_W), .EXP_W(EXP_W), .PROD_W(PROD_W)) nif ();

  norm_round_unit #(.MANT_W(MANT_W), .EXP_W(EXP_W), .PROD_W(PROD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (nif)
  );

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        ovf;
    logic        udf;
    logic        inx;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic chk_result(input exp_t t, input string sfx);
    chk({t.name, sfx, "/sign"}, 64'(nif.out_sign), 64'(t.sign));
    chk({t.name, sfx, "/exp"},  64'(nif.out_exp), 64'(t.exp));
    chk({t.name, sfx, "/frac"}, 64'(nif.out_frac), 64'(t.frac));
    chk({t.name, sfx, "/ovf"},  64'(nif.out_overflow), 64'(t.ovf));
    chk({t.name, sfx, "/udf"},  64'(nif.out_underflow), 64'(t.udf));
    chk({t.name, sfx, "/inx"},  64'(nif.out_inexact), 64'(t.inx));
  endtask

  task automatic run_op(input string name, input logic s, input logic [9:0] e,
                        input logic [47:0] f, input logic [7:0] xe, input logic [22:0] xf,
                        input logic xo, input logic xu, input logic xi,
                        input int xlat, input int stall);
    exp_t t;
    int   cyc;
    bit   seen;
    @(negedge clk);
    chk({name, "/in_ready_idle"}, 64'(nif.in_ready), 64'd1);
    nif.in_valid = 1'b1;
    nif.in_sign  = s;
    nif.in_exp   = e;
    nif.in_frac  = f;
    t = '{name, s, xe, xf, xo, xu, xi, xlat};
    sb.push_back(t);
    @(posedge clk);
    #1;
    nif.in_valid = 1'b0;
    nif.in_sign  = ~s;
    nif.in_exp   = 10'($urandom);
    nif.in_frac  = {16'($urandom), 32'($urandom)};
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (nif.out_valid) seen = 1'b1;
    end
    chk({name, "/latency"}, 64'(cyc), 64'(xlat));
    if (seen) begin
      t = sb.pop_front();
      chk_result(t, "");
      chk({name, "/in_ready_busy"}, 64'(nif.in_ready), 64'd0);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk({name, "/stall_valid"}, 64'(nif.out_valid), 64'd1);
        chk({name, "/stall_in_ready"}, 64'(nif.in_ready), 64'd0);
        chk_result(t, "/stall");
      end
      nif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      nif.out_ready = 1'b0;
      @(negedge clk);
      chk({name, "/valid_drop"}, 64'(nif.out_valid), 64'd0);
      chk({name, "/in_ready_back"}, 64'(nif.in_ready), 64'd1);
    end
    $display("op %-10s exp_in=%0d frac_in=%012h -> exp=%02h frac=%06h ovf=%0b udf=%0b inx=%0b lat=%0d",
             name, $signed(e), f, t.exp, t.frac, t.ovf, t.udf, t.inx, cyc);
  endtask

  initial begin
    rst           = 1'b1;
    nif.in_valid  = 1'b0;
    nif.in_sign   = 1'b0;
    nif.in_exp    = '0;
    nif.in_frac   = '0;
    nif.out_ready = 1'b0;
    #12;
    chk("reset/in_ready",  64'(nif.in_ready), 64'd1);
    chk("reset/out_valid", 64'(nif.out_valid), 64'd0);
    chk("reset/out_exp",   64'(nif.out_exp), 64'd0);
    chk("reset/out_frac",  64'(nif.out_frac), 64'd0);
    chk("reset/flags",     64'({nif.out_overflow, nif.out_underflow, nif.out_inexact}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    //      name          s     exp      frac                 exp    frac    o  u  i  lat stall
    run_op("t1_rshift",   1'b0, 10'd127, 48'h8000_0000_0000, 8'd128, 23'd0, 0, 0, 0, 2, 0);
    run_op("t2_tie_even", 1'b1, 10'd127, 48'h4000_0040_0000, 8'd127, 23'd0, 0, 0, 1, 2, 0);
    run_op("t2_tie_odd",  1'b0, 10'd127, 48'h4000_00C0_0000, 8'd127, 23'd2, 0, 0, 1, 2, 0);
    run_op("rnd_sticky",  1'b0, 10'd127, 48'h4000_0040_0001, 8'd127, 23'd1, 0, 0, 1, 2, 0);
    run_op("t3_carry",    1'b0, 10'd127, 48'h7FFF_FFC0_0000, 8'd128, 23'd0, 0, 0, 1, 2, 0);
    run_op("t4_lshift2",  1'b0, 10'd127, 48'h1000_0000_0000, 8'd125, 23'd0, 0, 0, 0, 4, 0);
    run_op("t4_udf",      1'b1, 10'd1,   48'h1000_0000_0000, 8'd0,   23'd0, 0, 1, 1, 3, 0);
    run_op("t5_ovf",      1'b0, 10'd254, 48'h8000_0000_0000, 8'hFF,  23'd0, 1, 0, 1, 2, 0);
    run_op("carry_ovf",   1'b1, 10'd254, 48'h7FFF_FFC0_0000, 8'hFF,  23'd0, 1, 0, 1, 2, 0);
    run_op("t5_zero",     1'b0, 10'd100, 48'h0,              8'd0,   23'd0, 0, 0, 0, 2, 0);
    run_op("rs_sticky",   1'b0, 10'd127, 48'h8000_0000_0001, 8'd128, 23'd0, 0, 0, 1, 2, 0);
    run_op("neg_exp",     1'b0, 10'h3FB, 48'h4000_0000_0000, 8'd0,   23'd0, 0, 1, 1, 2, 0);
    run_op("exp_zero",    1'b0, 10'd0,   48'h4000_0000_0000, 8'd0,   23'd0, 0, 1, 1, 2, 0);
    run_op("max_norm",    1'b0, 10'd254, 48'h4000_0000_0000, 8'd254, 23'd0, 0, 0, 0, 2, 0);
    run_op("t6_stall",    1'b1, 10'd127, 48'h5555_5540_0000, 8'd127, 23'h2AAAAA, 0, 0, 1, 2, 5);

    // Reset while normalising: in_ready must return at once, without a clock edge.
    @(negedge clk);
    nif.in_valid = 1'b1;
    nif.in_exp   = 10'd127;
    nif.in_frac  = 48'h0000_0100_0000;
    @(posedge clk);
    #1;
    nif.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_norm/in_ready_pre", 64'(nif.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_norm/in_ready", 64'(nif.in_ready), 64'd1);
    chk("rst_norm/out_valid", 64'(nif.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while a result is being presented: out_valid and data clear immediately.
    @(negedge clk);
    nif.in_valid = 1'b1;
    nif.in_exp   = 10'd254;
    nif.in_frac  = 48'h8000_0000_0000;
    @(posedge clk);
    #1;
    nif.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out/out_valid_pre", 64'(nif.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_out/out_valid", 64'(nif.out_valid), 64'd0);
    chk("rst_out/out_exp", 64'(nif.out_exp), 64'd0);
    chk("rst_out/ovf", 64'(nif.out_overflow), 64'd0);
    chk("rst_out/in_ready", 64'(nif.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    run_op("after_rst",   1'b0, 10'd127, 48'h2000_0000_0000, 8'd126, 23'd0, 0, 0, 0, 3, 2);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected $finish");
    $fatal(1, "timeout");
  end
endmodule
